// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter: clr wins over inc, holds at all-ones.
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/param_sequence_detector.sv
// Serial pattern detector with a loadable pattern/length, optional overlap,
// a registered match pulse and a saturating match total.
module param_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               valid_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pattern_len,
    input  logic               overlap_en,
    input  logic               load,
    input  logic               clear,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    state_e             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    // The oldest history bit only matters in the post-shift compare, so it is never stored.
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               det_q;
    logic               err_q;

    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] mask;
    logic               load_ok;
    logic               accept;
    logic               hit;
    logic               match;

    always_comb begin
        hist_d  = {hist_q, sequence_in};
        fill_d  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        load_ok = load && (pattern_len != '0) && (pattern_len <= LEN_W'(MAX_LEN));
        accept  = !load && !clear && valid_in && (state_q == RUN);
        hit     = (fill_d >= len_q) && ((hist_d & mask) == (pat_q & mask));
        match   = accept && hit;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            det_q <= match;
            if (load) begin
                if (load_ok) begin
                    state_q <= RUN;
                    pat_q   <= pattern;
                    len_q   <= pattern_len;
                    ovl_q   <= overlap_en;
                    hist_q  <= '0;
                    fill_q  <= '0;
                    err_q   <= 1'b0;
                end else begin
                    err_q   <= 1'b1;
                end
            end else if (clear) begin
                hist_q <= '0;
                fill_q <= '0;
            end else if (accept) begin
                hist_q <= hist_d[MAX_LEN-2:0];
                // Non-overlap: the matched bits must not seed the next match.
                fill_q <= (match && !ovl_q) ? '0 : fill_d;
            end
        end
    end

    seq_det_sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clock(clock),
        .reset(reset),
        .clr  (load_ok || (clear && !load)),
        .inc  (match),
        .count(match_count)
    );

    assign detector_out = det_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Randomised and directed checks of param_sequence_detector against a
// bit-queue reference model (default counter and a 2-bit counter instance).
module tb_param_sequence_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sequence_in = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pattern_len = '0;
    logic       overlap_en = 1'b0;
    logic       load = 1'b0;
    logic       clear = 1'b0;

    logic       det8, det2, err8, err2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    bit       q[$];
    bit       m_run, m_ovl, m_det, m_err;
    bit [7:0] m_pat;
    int       m_len, m_cnt;

    always #5 clock = ~clock;

    param_sequence_detector dut (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .valid_in(valid_in),
        .pattern(pattern), .pattern_len(pattern_len), .overlap_en(overlap_en),
        .load(load), .clear(clear), .detector_out(det8), .match_count(cnt8), .cfg_err(err8)
    );

    param_sequence_detector #(.CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .valid_in(valid_in),
        .pattern(pattern), .pattern_len(pattern_len), .overlap_en(overlap_en),
        .load(load), .clear(clear), .detector_out(det2), .match_count(cnt2), .cfg_err(err2)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit tail_matches();
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (q[q.size()-1-k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_run = 0; m_ovl = 0; m_det = 0; m_err = 0; m_pat = '0; m_len = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        m_det = 0;
        if (load) begin
            if (pattern_len >= 1 && pattern_len <= 8) begin
                m_run = 1; m_pat = pattern; m_len = int'(pattern_len); m_ovl = overlap_en;
                q.delete(); m_cnt = 0; m_err = 0;
            end else begin
                m_err = 1;
            end
        end else if (clear) begin
            q.delete(); m_cnt = 0;
        end else if (valid_in && m_run) begin
            q.push_back(sequence_in);
            if (q.size() > 16) void'(q.pop_front());
            m_det = tail_matches();
            if (m_det) begin
                if (m_cnt < 100000) m_cnt++;
                if (!m_ovl) q.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".det"},   det8, m_det);
        chk({tag, ".det_s"}, det2, m_det);
        chk({tag, ".cnt"},   cnt8, sat(m_cnt, 255));
        chk({tag, ".cnt_s"}, cnt2, sat(m_cnt, 3));
        chk({tag, ".err"},   err8, m_err);
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
        load = 0; clear = 0; valid_in = 0;
    endtask

    task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
        pattern = p; pattern_len = l; overlap_en = o; load = 1;
        tick("load");
        pattern = $urandom; pattern_len = 4'($urandom); overlap_en = 1'($urandom);
    endtask

    task automatic send(input bit b, input bit exp_det, input string tag);
        sequence_in = b; valid_in = 1;
        tick(tag);
        chk({tag, ".pulse"}, det8, exp_det);
    endtask

    task automatic do_reset();
        #2 reset = 0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.zero", {det8, cnt8, err8}, 0);
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        bit ovl_exp[7] = '{0, 0, 0, 1, 0, 0, 1};
        bit non_exp[7] = '{0, 0, 0, 1, 0, 0, 0};
        bit strm[7]    = '{1, 0, 1, 1, 0, 1, 1};

        model_reset();
        #1 check_all("por");
        @(negedge clock);
        reset = 1;

        // idle: bits ignored before any load
        send(1, 0, "idle0"); send(1, 0, "idle1");

        // overlap
        do_load(8'b1011, 4'd4, 1'b1);
        for (int i = 0; i < 7; i++) send(strm[i], ovl_exp[i], "ovl");
        chk("ovl.count", cnt8, 2);

        // non-overlap
        do_load(8'b1011, 4'd4, 1'b0);
        for (int i = 0; i < 7; i++) send(strm[i], non_exp[i], "nonovl");
        chk("nonovl.count", cnt8, 1);

        // valid gaps
        do_load(8'b1011, 4'd4, 1'b1);
        send(1, 0, "gap"); send(0, 0, "gap");
        for (int i = 0; i < 3; i++) begin
            sequence_in = 1'($urandom);
            tick("gap.idle");
            chk("gap.det_low", det8, 0);
        end
        send(1, 0, "gap"); send(1, 1, "gap.last");

        // saturation on the 2-bit counter
        do_load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) send(1, 1, "sat");
        chk("sat.cnt_s", cnt2, 3);
        chk("sat.cnt", cnt8, 6);

        // invalid load keeps the old pattern
        do_load(8'b1011, 4'd4, 1'b1);
        do_load(8'b0110, 4'd0, 1'b0);
        chk("badload.err", err8, 1);
        send(1, 0, "badload"); send(0, 0, "badload"); send(1, 0, "badload"); send(1, 1, "badload.hit");
        chk("badload.err_sticky", err8, 1);
        do_load(8'b11, 4'd2, 1'b0);
        chk("goodload.err_clr", err8, 0);

        // load/clear discard the bit in the same cycle
        send(1, 0, "prio");
        sequence_in = 1; valid_in = 1; clear = 1;
        tick("prio.clear");
        chk("prio.clear_det", det8, 0);
        send(1, 0, "prio"); send(1, 1, "prio.hit");

        // reset mid-stream
        do_load(8'b1011, 4'd4, 1'b1);
        send(1, 0, "rst"); send(0, 0, "rst"); send(1, 0, "rst");
        do_reset();
        send(1, 0, "rst.after");
        for (int i = 0; i < 4; i++) send(strm[i], 0, "rst.idle");

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 199);
            int rl = $urandom_range(0, 9);
            if (r == 199) begin
                do_reset();
                continue;
            end
            load = (r < 8);
            clear = (r >= 8 && r < 12);
            pattern = $urandom;
            overlap_en = 1'($urandom);
            pattern_len = (rl < 7) ? 4'($urandom_range(1, 4)) :
                          (rl == 7) ? 4'd0 : 4'($urandom_range(5, 15));
            valid_in = ($urandom_range(0, 3) != 0);
            sequence_in = 1'($urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_sequence_detector.md
PARAM_SEQUENCE_DETECTOR -- requirements
Module: param_sequence_detector

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have parameter LEN_W, default $clog2(MAX_LEN+1), width of pattern_len.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sequence_in, input, 1 bit: serial data bit.
REQ-007 SHALL have port valid_in, input, 1 bit: sequence_in is accepted on an edge only when high.
REQ-008 SHALL have port pattern, input, MAX_LEN bits: target pattern; the first-received bit is pattern[len-1] and the last is pattern[0].
REQ-009 SHALL have port pattern_len, input, LEN_W bits: active pattern length.
REQ-010 SHALL have port overlap_en, input, 1 bit: 1 = overlapping matches, 0 = non-overlapping.
REQ-011 SHALL have port load, input, 1 bit: latch pattern, pattern_len and overlap_en.
REQ-012 SHALL have port clear, input, 1 bit: flush the history and zero the count.
REQ-013 SHALL have port detector_out, output, 1 bit: registered Moore match pulse.
REQ-014 SHALL have port match_count, output, CNT_W bits: saturating match total.
REQ-015 SHALL have port cfg_err, output, 1 bit: sticky flag for an invalid load.

Function
REQ-016 SHALL implement a 2-state FSM.
- IDLE: no config loaded; valid_in ignored; detector_out=0.
- RUN: detecting.
REQ-017 SHALL make transitions only on load.
- A valid load (1 <= pattern_len <= MAX_LEN), from either state: latch the config, zero history and fill, go to RUN, clear cfg_err.
- An invalid load: keep the state and config, set cfg_err.
REQ-018 SHALL, in RUN with valid_in=1, shift history left with sequence_in entering bit 0, and increment fill (saturating at MAX_LEN).
REQ-019 SHALL flag a match when the post-shift fill >= len and history[len-1:0] == pattern_q[len-1:0].
REQ-020 SHALL register detector_out as the match result: high for exactly the one cycle after the edge that accepted the final pattern bit (latency 1), and 0 otherwise.
REQ-021 SHALL, on a match with overlap_q=0, set fill to 0 so that no bits of the matched pattern count toward the next match; with overlap_q=1, fill is unaffected.
REQ-022 SHALL increment match_count by 1 per match, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL hold history, fill and count, and drive detector_out to 0, in any cycle with valid_in=0.
REQ-024 SHALL give load priority over clear, and clear priority over valid_in; a bit presented in the same cycle as load or clear is discarded and detector_out is 0 next cycle.
REQ-025 SHALL make a valid load also zero match_count; clear leaves the state and config unchanged.
REQ-026 SHALL have the pattern, pattern_len and overlap_en inputs affect nothing except at load.

Reset
REQ-027 SHALL, on reset=0, immediately force: state=IDLE, history=0, fill=0, config=0, detector_out=0, match_count=0, cfg_err=0.
REQ-028 SHALL, after reset mid-stream, discard all partial matches and require a new load before any detection.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, RUN) and the default MAX_LEN/CNT_W constants in shared package seq_det_pkg.
REQ-030 SHALL implement the saturating counter as sub-module seq_det_sat_counter (inputs: clock, reset, clr, inc; output: count).

Verification
REQ-031 SHALL verify overlap: load 1011/len 4/overlap 1, then stream 1,0,1,1,0,1,1 -> detector_out pulses after bits 4 and 7; match_count=2.
REQ-032 SHALL verify non-overlap: same stream with overlap 0 -> a single pulse after bit 4; match_count=1.
REQ-033 SHALL verify valid gaps: stream 1,0,(valid low 3 cycles),1,1 -> one pulse after the last bit; detector_out=0 during the gap.
REQ-034 SHALL verify saturation: CNT_W=2, len 1 pattern 1, six accepted 1s -> match_count stays 3.
REQ-035 SHALL verify invalid load: load with pattern_len=0 while in RUN -> cfg_err=1, and the prior pattern is still detected; a following valid load clears cfg_err.
REQ-036 SHALL verify reset mid-stream: assert reset after 1,0,1 of 1011 -> outputs are 0 immediately; after release with no load, the input 1 gives no pulse and the state is IDLE.
